bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using double-dabble (shift-and-add-3), one input bit per clock.
- Start/busy/done handshake; BCD result registered and held stable between conversions.
- Adds an overflow flag for results that need more digits than configured.
- Sits between datapath counters/results and the display path (7-segment digit decoders).

Parameters:
- WIDTH, 8, binary input width in bits (>=1).
- DIGITS, 3, number of BCD output digits (>=1); 3 covers WIDTH=8 without overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only when busy=0.
- bin  input  WIDTH  binary operand; captured on the accepted start cycle.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bcd/ovf valid and updated this cycle.
- bcd  output  4*DIGITS  packed BCD result, digit 0 = bcd[3:0] (units).
- ovf  output  1  result >= 10^DIGITS; qualified by done, held with bcd.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, bcd=0, ovf=0; scratch registers and bit counter cleared. Reset overrides start and aborts any conversion in progress; no done is produced for an aborted conversion.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: latch bin into the shift register; clear the BCD scratch and the sticky overflow; load the counter with WIDTH; go to SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle, in this order:
  - every scratch digit >4 gets +3 (4-bit add, no carry between digits);
  - shift {scratch, shreg} left by 1, so the MSB of shreg enters scratch bit 0;
  - the bit shifted out of the top digit ORs into sticky overflow;
  - decrement the counter; after WIDTH shift cycles go to DONE.
- DONE, one cycle:
  - bcd<=scratch, ovf<=sticky, done=1, busy=0;
  - go to IDLE, or straight to SHIFT if start=1 that cycle (back-to-back accepted, new bin latched).
- Latency: start accepted at edge T -> done=1 in the cycle after edge T+WIDTH+1.
- Throughput: one conversion per WIDTH+1 cycles.
- bcd/ovf change only on the DONE transition; they hold the previous result throughout SHIFT.
- start while busy=1 is ignored, not queued; bin changes during SHIFT have no effect.
- Overflow: ovf=1 iff bin >= 10^DIGITS; bcd then holds bin mod 10^DIGITS.
- Widths: counter is clog2(WIDTH+1) bits; scratch is 4*DIGITS bits; all digit arithmetic is 4-bit unsigned.
- Digits never exceed 9 in bcd.

Optional Feature:
- Macro: BIN2BCD_SEG7_OUT_EN.
- Defined:
  - Adds output port seg, 7*DIGITS wide; digit k occupies seg[7k+6:7k].
  - Active-low, bit order abcdefg (bit6=a, bit0=g), using the team's standard table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Leading-zero blanking: any zero digit above the most significant nonzero digit shows 1111111; digit 0 is never blanked.
  - seg is registered and updated in the same cycle as bcd; reset value shows digit 0 as "0", all other digits blank.
- Undefined: no seg port, no decode logic; all other behaviour unchanged.

Test Plan:
- Defaults, bin=8'd255, start at edge T -> done pulse in cycle after T+9; bcd=12'h255, ovf=0, busy high for 8 cycles.
- bin=8'd0 -> bcd=12'h000, ovf=0; bin=8'd100 -> bcd=12'h100.
- WIDTH=8, DIGITS=2, bin=8'd157 -> bcd=8'h57, ovf=1; then bin=8'd99 -> bcd=8'h99, ovf=0.
- bin=8'd42 started; pulse start with bin=8'd200 at cycle 3 of SHIFT -> ignored; result bcd=12'h042; bcd keeps the prior value until done.
- Assert rst at SHIFT cycle 4 -> next cycle busy=0, done=0, bcd=0, ovf=0; no done follows; a new start of 8'd9 gives bcd=12'h009.
- Back-to-back: start held high continuously with bin=8'd10 then 8'd11 -> done every 9 cycles, bcd 12'h010 then 12'h011. With BIN2BCD_SEG7_OUT_EN and bin=8'd7 -> seg={1111111,1111111,0001111}.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional registered 7-segment output with leading-zero blanking when BIN2BCD_SEG7_OUT_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
`ifdef BIN2BCD_SEG7_OUT_EN
  ,
  output logic [7*DIGITS-1:0] seg
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic                sticky;
  logic [CW-1:0]       cnt;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nxt;
  logic                accept;

  // Add-3 per digit happens before the shift, so the shifted-out top bit reflects true overflow
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] > 4'd4) begin
        adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
    scratch_nxt = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
  end

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state == S_SHIFT);

`ifdef BIN2BCD_SEG7_OUT_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_nxt;
  logic [7*DIGITS-1:0] seg_rst;

  // Walk down from the top digit; blanking stops at the first nonzero digit
  always_comb begin
    logic lead;
    lead    = 1'b1;
    seg_nxt = '1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && scratch[4*k +: 4] == 4'd0) begin
        seg_nxt[7*k +: 7] = 7'b1111111;
      end else begin
        lead              = 1'b0;
        seg_nxt[7*k +: 7] = seg7(scratch[4*k +: 4]);
      end
    end
    seg_nxt[6:0] = seg7(scratch[3:0]);
  end

  always_comb begin
    seg_rst      = '1;
    seg_rst[6:0] = 7'b0000001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= seg_rst;
    end else if (state == S_DONE) begin
      seg <= seg_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        bcd <= scratch;
        ovf <= sticky;
      end

      case (state)
        S_SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= shreg << 1;
          sticky  <= sticky | adj[4*DIGITS-1];
          cnt     <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            shreg   <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CNT_LOAD;
            state   <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit instance and a 2-digit instance for the overflow cases.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start, start2;
  logic [7:0]  bin, bin2;
  logic        busy, done, ovf;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;
`ifdef BIN2BCD_SEG7_OUT_EN
  logic [20:0] seg;
  logic [13:0] seg2;
`endif

  int nvec = 0;
  int nerr = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
`ifdef BIN2BCD_SEG7_OUT_EN
    , .seg(seg)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BIN2BCD_SEG7_OUT_EN
    , .seg(seg2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on the selected instance, returns edges-to-done and busy-high cycle count
  task automatic convert(input bit sel, input logic [7:0] v, output int lat, output int bcy);
    if (sel) begin bin2 = v; start2 = 1'b1; end
    else     begin bin  = v; start  = 1'b1; end
    step();
    start  = 1'b0;
    start2 = 1'b0;
    lat = 0;
    bcy = 0;
    while (!(sel ? done2 : done) && lat < 40) begin
      if (sel ? busy2 : busy) bcy++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nvec++; if (bcd !== 12'h000) begin nerr++; $display("FAIL reset_bcd: got %h want 000", bcd); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`ifdef BIN2BCD_SEG7_OUT_EN
    nvec++;
    if (seg !== {7'b1111111, 7'b1111111, 7'b0000001}) begin
      nerr++; $display("FAIL reset_seg: got %b want 111111111111110000001", seg);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, bcy;
    convert(1'b0, 8'd255, lat, bcy);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL lat_255: got %0d want 9", lat); end
    nvec++; if (bcy !== 8) begin nerr++; $display("FAIL busy_255: got %0d want 8", bcy); end
    nvec++; if (bcd !== 12'h255) begin nerr++; $display("FAIL bcd_255: got %h want 255", bcd); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_255: got %b want 0", ovf); end
    step();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse_width: got %b want 0", done); end
    convert(1'b0, 8'd0, lat, bcy);
    nvec++; if (bcd !== 12'h000) begin nerr++; $display("FAIL bcd_0: got %h want 000", bcd); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_0: got %b want 0", ovf); end
    convert(1'b0, 8'd100, lat, bcy);
    nvec++; if (bcd !== 12'h100) begin nerr++; $display("FAIL bcd_100: got %h want 100", bcd); end
  endtask

  task automatic test_overflow();
    int lat, bcy;
    convert(1'b1, 8'd157, lat, bcy);
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL lat_157: got %0d want 9", lat); end
    nvec++; if (bcd2 !== 8'h57) begin nerr++; $display("FAIL bcd_157: got %h want 57", bcd2); end
    nvec++; if (ovf2 !== 1'b1) begin nerr++; $display("FAIL ovf_157: got %b want 1", ovf2); end
    convert(1'b1, 8'd99, lat, bcy);
    nvec++; if (bcd2 !== 8'h99) begin nerr++; $display("FAIL bcd_99: got %h want 99", bcd2); end
    nvec++; if (ovf2 !== 1'b0) begin nerr++; $display("FAIL ovf_99: got %b want 0", ovf2); end
  endtask

  task automatic test_ignore_start();
    int lat;
    bin = 8'd42; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    bin = 8'd200; start = 1'b1;
    step();
    start = 1'b0;
    nvec++; if (bcd !== 12'h100) begin nerr++; $display("FAIL hold_during_shift: got %h want 100", bcd); end
    lat = 3;
    while (!done && lat < 40) begin step(); lat++; end
    nvec++; if (lat !== 9) begin nerr++; $display("FAIL lat_ignore: got %0d want 9", lat); end
    nvec++; if (bcd !== 12'h042) begin nerr++; $display("FAIL bcd_42: got %h want 042", bcd); end
    step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL start_queued: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    int lat, bcy;
    int seen;
    bin = 8'd77; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL abort_done: got %b want 0", done); end
    nvec++; if (bcd !== 12'h000) begin nerr++; $display("FAIL abort_bcd: got %h want 000", bcd); end
    nvec++; if (ovf !== 1'b0) begin nerr++; $display("FAIL abort_ovf: got %b want 0", ovf); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      step();
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    convert(1'b0, 8'd9, lat, bcy);
    nvec++; if (bcd !== 12'h009) begin nerr++; $display("FAIL bcd_9: got %h want 009", bcd); end
  endtask

  task automatic test_back_to_back();
    int n;
    bin = 8'd10; start = 1'b1;
    step();
    bin = 8'd11;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    nvec++; if (n !== 9) begin nerr++; $display("FAIL b2b_first_lat: got %0d want 9", n); end
    nvec++; if (bcd !== 12'h010) begin nerr++; $display("FAIL b2b_bcd_10: got %h want 010", bcd); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy: got %b want 1", busy); end
    n = 0;
    step(); n++;
    while (!done && n < 40) begin step(); n++; end
    nvec++; if (n !== 9) begin nerr++; $display("FAIL b2b_period: got %0d want 9", n); end
    nvec++; if (bcd !== 12'h011) begin nerr++; $display("FAIL b2b_bcd_11: got %h want 011", bcd); end
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

`ifdef BIN2BCD_SEG7_OUT_EN
  task automatic test_seg();
    int lat, bcy;
    convert(1'b0, 8'd7, lat, bcy);
    nvec++;
    if (seg !== {7'b1111111, 7'b1111111, 7'b0001111}) begin
      nerr++; $display("FAIL seg_7: got %b want 111111111111110001111", seg);
    end
    convert(1'b0, 8'd205, lat, bcy);
    nvec++;
    if (seg !== {7'b0010010, 7'b0000001, 7'b0100100}) begin
      nerr++; $display("FAIL seg_205: got %b want 001001000000010100100", seg);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_abort();
    test_back_to_back();
`ifdef BIN2BCD_SEG7_OUT_EN
    test_seg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
